// File: rtl/interpo_table_reader.sv
// Streaming linear interpolator: fetches two adjacent entries of a cyclic table over a read-only RAM port.
// Define INTERPO_RD_ROUND_EN for round-half-up interpolation; the default build floors.
module interpo_table_reader #(
    parameter int unsigned DEPTH  = 40,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W+FRAC_W-1:0] in_index,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     range_err,
    input  logic                     err_clr,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_chipselect,
    output logic                     mem_write,
    output logic [3:0]               mem_byteenable,
    output logic                     mem_clken,
    input  logic [DATA_W-1:0]        mem_readdata
);

    localparam int unsigned IDX_W  = ADDR_W + FRAC_W;
    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PROD_W = DATA_W + FRAC_W + 2;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_CALC,
        S_OUT
    } state_t;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   idx_j_q,     idx_j_d;
    logic [FRAC_W-1:0]   frac_q,      frac_d;
    logic [DATA_W-1:0]   a_q,         a_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q,  in_ready_d;
    logic                range_err_q, range_err_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic                mem_cs_q,    mem_cs_d;

    // Index decode: out-of-range integer parts collapse onto the last entry with zero fraction.
    logic [ADDR_W-1:0] int_c;
    logic              oor_c;
    logic [ADDR_W-1:0] idx_i_c;
    logic [ADDR_W-1:0] idx_j_c;
    logic [FRAC_W-1:0] frac_c;

    always_comb begin
        int_c   = in_index[IDX_W-1:FRAC_W];
        oor_c   = (int_c >= ADDR_W'(DEPTH));
        idx_i_c = oor_c ? LAST_IDX : int_c;
        frac_c  = oor_c ? '0 : in_index[FRAC_W-1:0];
        idx_j_c = (idx_i_c == LAST_IDX) ? '0 : ADDR_W'(idx_i_c + 1'b1);
    end

    // Interpolation datapath; b arrives straight from the RAM during CALC.
    logic signed [DIFF_W-1:0] diff_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod_rnd_c;
    logic signed [PROD_W-1:0] step_c;
    logic signed [PROD_W-1:0] sum_c;
    logic [DATA_W-1:0]        y_c;

    always_comb begin
        diff_c = DIFF_W'($signed(mem_readdata)) - DIFF_W'($signed(a_q));
        prod_c = PROD_W'(diff_c) * PROD_W'($signed({1'b0, frac_q}));
`ifdef INTERPO_RD_ROUND_EN
        prod_rnd_c = prod_c + $signed({{(PROD_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}});
`else
        prod_rnd_c = prod_c;
`endif
        step_c = prod_rnd_c >>> FRAC_W;
        sum_c  = PROD_W'($signed(a_q)) + step_c;
        if (sum_c > SAT_MAX) begin
            y_c = DATA_W'(SAT_MAX);
        end else if (sum_c < SAT_MIN) begin
            y_c = DATA_W'(SAT_MIN);
        end else begin
            y_c = DATA_W'(sum_c);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_j_d     = idx_j_q;
        frac_d      = frac_q;
        a_d         = a_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        range_err_d = range_err_q;
        mem_addr_d  = mem_addr_q;
        mem_cs_d    = mem_cs_q;

        // A new out-of-range accept overrides a simultaneous clear.
        if (err_clr) begin
            range_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (oor_c) begin
                        range_err_d = 1'b1;
                    end
                    idx_j_d    = idx_j_c;
                    frac_d     = frac_c;
                    mem_addr_d = idx_i_c;
                    mem_cs_d   = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = S_RD0;
                end
            end
            S_RD0: begin
                mem_addr_d = idx_j_q;
                mem_cs_d   = 1'b1;
                state_d    = S_RD1;
            end
            S_RD1: begin
                a_d      = mem_readdata;
                mem_cs_d = 1'b0;
                state_d  = S_CALC;
            end
            S_CALC: begin
                out_data_d  = y_c;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                mem_cs_d    = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_j_q     <= '0;
            frac_q      <= '0;
            a_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            range_err_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_cs_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_j_q     <= idx_j_d;
            frac_q      <= frac_d;
            a_q         <= a_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            range_err_q <= range_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_cs_q    <= mem_cs_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign range_err      = range_err_q;
    assign mem_address    = mem_addr_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_interpo_table_reader.sv
// Bench for interpo_table_reader: behavioural RAM, directed table cases, then randomized traffic.
module tb_interpo_table_reader;

    localparam int unsigned DEPTH  = 40;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned DATA_W = 32;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [ADDR_W+FRAC_W-1:0] in_index;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     range_err;
    logic                     err_clr;
    logic [ADDR_W-1:0]        mem_address;
    logic                     mem_chipselect;
    logic                     mem_write;
    logic [3:0]               mem_byteenable;
    logic                     mem_clken;
    logic [DATA_W-1:0]        mem_readdata;

    int compared   = 0;
    int mismatched = 0;
    logic err_model;

    interpo_table_reader #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .range_err(range_err), .err_clr(err_clr),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port: registered address, unregistered read data.
    logic [DATA_W-1:0] tbl [0:63];
    logic [ADDR_W-1:0] ram_a_q;
    always_ff @(posedge clk) begin
        if (mem_chipselect && mem_clken) ram_a_q <= mem_address;
    end
    assign mem_readdata = tbl[ram_a_q];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Reference: straight arithmetic on the table contents.
    function automatic logic signed [63:0] ref_y(input logic [13:0] idx);
        longint ii, ff, jj, a, b, p, y;
        ii = longint'(idx[13:8]);
        ff = longint'(idx[7:0]);
        if (ii >= DEPTH) begin ii = DEPTH - 1; ff = 0; end
        jj = (ii + 1) % DEPTH;
        a  = longint'($signed(tbl[ii]));
        b  = longint'($signed(tbl[jj]));
        p  = (b - a) * ff;
`ifdef INTERPO_RD_ROUND_EN
        p  = p + 128;
`endif
        y  = a + (p >>> 8);
        if (y > 64'sd2147483647)  y = 64'sd2147483647;
        if (y < -64'sd2147483648) y = -64'sd2147483648;
        return 64'(y);
    endfunction

    task automatic xact(input string tag, input logic [13:0] idx, input logic signed [63:0] exp_y,
                        input int hold, input logic clr_same);
        int ii, jj, n;
        ii = int'(idx[13:8]);
        if (ii >= DEPTH) ii = DEPTH - 1;
        jj = (ii + 1) % DEPTH;
        n  = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_index = idx;
        err_clr  = clr_same;
        @(posedge clk); #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        if (clr_same) err_model = 1'b0;
        if (int'(idx[13:8]) >= DEPTH) err_model = 1'b1;
        chk({tag, ":range_err"}, 64'(range_err), 64'(err_model));
        chk({tag, ":addr_i"}, 64'(mem_address), 64'(ii));
        chk({tag, ":cs_rd0"}, 64'(mem_chipselect), 64'(1));
        chk({tag, ":in_ready_busy"}, 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        chk({tag, ":addr_j"}, 64'(mem_address), 64'(jj));
        chk({tag, ":cs_rd1"}, 64'(mem_chipselect), 64'(1));
        @(posedge clk); #1;
        chk({tag, ":valid_early"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk({tag, ":valid"}, 64'(out_valid), 64'(1));
        chk({tag, ":data"}, 64'($signed(out_data)), exp_y);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            chk({tag, ":hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, ":hold_data"}, 64'($signed(out_data)), exp_y);
            chk({tag, ":hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ":ready_after"}, 64'(in_ready), 64'(1));
        chk({tag, ":valid_after"}, 64'(out_valid), 64'(0));
        chk({tag, ":cs_idle"}, 64'(mem_chipselect), 64'(0));
        chk({tag, ":addr_held"}, 64'(mem_address), 64'(jj));
    endtask

    initial begin
        logic [13:0] ridx;
        logic        rclr;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_index  = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        err_model = 1'b0;
        for (int k = 0; k < 64; k++) tbl[k] = 32'(1000 * k);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst:in_ready",  64'(in_ready), 64'(1));
        chk("rst:out_valid", 64'(out_valid), 64'(0));
        chk("rst:out_data",  64'(out_data), 64'(0));
        chk("rst:range_err", 64'(range_err), 64'(0));
        chk("rst:cs",        64'(mem_chipselect), 64'(0));
        chk("rst:addr",      64'(mem_address), 64'(0));
        chk("const:write",   64'(mem_write), 64'(0));
        chk("const:be",      64'(mem_byteenable), 64'(15));
        chk("const:clken",   64'(mem_clken), 64'(1));

        xact("mid",  {6'd3, 8'h80},  64'(3500),  0, 1'b0);
        xact("wrap", {6'd39, 8'h40}, 64'(29250), 0, 1'b0);
        xact("oor",  {6'd45, 8'h10}, 64'(39000), 0, 1'b0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr   = 1'b0;
        err_model = 1'b0;
        chk("err_clr", 64'(range_err), 64'(0));

        tbl[0] = 32'(0);
        tbl[1] = 32'(-3);
`ifdef INTERPO_RD_ROUND_EN
        xact("neg_round", {6'd0, 8'h80}, -64'sd1, 0, 1'b0);
`else
        xact("neg_floor", {6'd0, 8'h80}, -64'sd2, 0, 1'b0);
`endif
        tbl[1] = 32'(1000);

        xact("stall", {6'd5, 8'h00}, 64'(5000), 3, 1'b0);

        // Reset during RD1 must drop the transaction without any output.
        in_valid = 1'b1;
        in_index = {6'd7, 8'h40};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_mid:valid", 64'(out_valid), 64'(0));
        chk("rst_mid:ready", 64'(in_ready), 64'(1));
        chk("rst_mid:cs",    64'(mem_chipselect), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        reset     = 1'b0;
        err_model = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("rst_mid:no_output", 64'(out_valid), 64'(0));
        end
        chk("rst_mid:ready_after", 64'(in_ready), 64'(1));
        xact("post_rst", {6'd2, 8'h00}, 64'(2000), 0, 1'b0);

        xact("set_wins", {6'd50, 8'h00}, 64'(39000), 0, 1'b1);

        for (int t = 0; t < 24; t++) begin
            if (t % 6 == 0) begin
                for (int k = 0; k < 64; k++) tbl[k] = $urandom();
            end
            ridx = 14'($urandom_range(0, 16383));
            rclr = ($urandom_range(0, 3) == 0);
            xact("rand", ridx, ref_y(ridx), int'($urandom_range(0, 2)), rclr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
